// File: rtl/axi_ram_slave.sv
// AXI3 RAM responder: one read and one write burst in flight, FIXED/INCR up to 16 beats.
// Optional WRAP burst support is enabled by defining AXI_RAM_SLAVE_WRAP_EN.
module axi_ram_slave #(
    parameter int ADDR_BITS = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    typedef enum logic {R_IDLE, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    logic [31:0] mem [2**ADDR_BITS];

    r_state_e    r_state_q, r_state_d;
    logic [3:0]  rid_q, rid_d, rlen_q, rlen_d, rbeat_q, rbeat_d;
    logic [31:0] raddr_q, raddr_d;
    logic [2:0]  rsize_q, rsize_d;
    logic [1:0]  rburst_q, rburst_d;

    w_state_e    w_state_q, w_state_d;
    logic [3:0]  bid_q, bid_d, wlen_q, wlen_d, wbeat_q, wbeat_d;
    logic [31:0] waddr_q, waddr_d;
    logic [2:0]  wsize_q, wsize_d;
    logic [1:0]  wburst_q, wburst_d;
    logic        werr_q, werr_d;

    logic        en_q;
    logic        rerr, wcfg_err, mem_we;
    logic        unused_ok;

    assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] sz,
                                              input logic [1:0] bu, input logic [3:0] len);
        logic [31:0] res;
`ifdef AXI_RAM_SLAVE_WRAP_EN
        logic [31:0] mask;
`else
        logic unused_len;
`endif
        res = a + (32'd1 << sz);
`ifdef AXI_RAM_SLAVE_WRAP_EN
        // window mask is (len+1)<<size bytes; only the in-window bits advance
        mask = ((32'(len) + 32'd1) << sz) - 32'd1;
        if (bu == 2'b10) res = (a & ~mask) | (res & mask);
`else
        unused_len = ^len;
`endif
        if (bu == 2'b00) res = a;
        return res;
    endfunction

    function automatic logic cfg_error(input logic [2:0] sz, input logic [1:0] bu,
                                       input logic [3:0] len);
`ifdef AXI_RAM_SLAVE_WRAP_EN
        return (sz > 3'd2) || ((bu == 2'b10) && !(len inside {4'd1, 4'd3, 4'd7, 4'd15}));
`else
        logic unused_cfg;
        unused_cfg = ^{bu, len};
        return sz > 3'd2;
`endif
    endfunction

    assign arready  = en_q && (r_state_q == R_IDLE);
    assign rvalid   = (r_state_q == R_DATA);
    assign rid      = rid_q;
    assign rlast    = rvalid && (rbeat_q == rlen_q);
    assign rerr     = cfg_error(rsize_q, rburst_q, rlen_q);
    assign rresp    = (rvalid && rerr) ? 2'b10 : 2'b00;
    assign rdata    = (rvalid && !rerr) ? mem[raddr_q[ADDR_BITS+1:2]] : '0;

    assign awready  = en_q && (w_state_q == W_IDLE);
    assign wready   = (w_state_q == W_DATA);
    assign bvalid   = (w_state_q == W_RESP);
    assign bid      = bid_q;
    assign wcfg_err = cfg_error(wsize_q, wburst_q, wlen_q);
    assign bresp    = (bvalid && (werr_q || wcfg_err)) ? 2'b10 : 2'b00;
    assign mem_we   = wready && wvalid && !wcfg_err;

    always_comb begin
        r_state_d = r_state_q;
        rid_d     = rid_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rsize_d   = rsize_q;
        rburst_d  = rburst_q;
        rbeat_d   = rbeat_q;
        case (r_state_q)
            R_IDLE: if (arvalid && arready) begin
                rid_d     = arid;
                raddr_d   = araddr;
                rlen_d    = arlen;
                rsize_d   = arsize;
                rburst_d  = arburst;
                rbeat_d   = '0;
                r_state_d = R_DATA;
            end
            R_DATA: if (rready) begin
                rbeat_d = rbeat_q + 4'd1;
                raddr_d = next_addr(raddr_q, rsize_q, rburst_q, rlen_q);
                if (rbeat_q == rlen_q) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_d = w_state_q;
        bid_d     = bid_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wsize_d   = wsize_q;
        wburst_d  = wburst_q;
        wbeat_d   = wbeat_q;
        werr_d    = werr_q;
        case (w_state_q)
            W_IDLE: if (awvalid && awready) begin
                bid_d     = awid;
                waddr_d   = awaddr;
                wlen_d    = awlen;
                wsize_d   = awsize;
                wburst_d  = awburst;
                wbeat_d   = '0;
                werr_d    = 1'b0;
                w_state_d = W_DATA;
            end
            W_DATA: if (wvalid) begin
                wbeat_d = wbeat_q + 4'd1;
                waddr_d = next_addr(waddr_q, wsize_q, wburst_q, wlen_q);
                // beat count ends the burst; wlast only flags disagreement
                if (wlast != (wbeat_q == wlen_q)) werr_d = 1'b1;
                if (wbeat_q == wlen_q) w_state_d = W_RESP;
            end
            W_RESP: if (bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            en_q      <= 1'b0;
            r_state_q <= R_IDLE;
            rid_q     <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rbeat_q   <= '0;
            w_state_q <= W_IDLE;
            bid_q     <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            wbeat_q   <= '0;
            werr_q    <= 1'b0;
        end else begin
            en_q      <= 1'b1;
            r_state_q <= r_state_d;
            rid_q     <= rid_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rsize_q   <= rsize_d;
            rburst_q  <= rburst_d;
            rbeat_q   <= rbeat_d;
            w_state_q <= w_state_d;
            bid_q     <= bid_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wsize_q   <= wsize_d;
            wburst_q  <= wburst_d;
            wbeat_q   <= wbeat_d;
            werr_q    <= werr_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[waddr_q[ADDR_BITS+1:2]][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule
